piso_serializer: RTL

- Parallel-in/serial-out stage that feeds the serial `data` input of the bit-pattern detector FSMs.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB first.
- Drives 0 on the serial line whenever it is idle, so downstream detectors see a quiet line.

---
 rtl/piso_serializer_if.sv | 22 ++
 rtl/piso_serializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel word handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             data;
    logic             data_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, din_valid,
        input  din_ready, data, data_valid, busy, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, data, data_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - MSB-first parallel-in/serial-out stage; SER_PARITY_EN appends an even-parity bit
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic last_bit;
    logic din_ready;
    logic accept;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        data_d       = 1'b0;
        data_valid_d = 1'b0;
        done_d       = 1'b0;
`ifdef SER_PARITY_EN
        parity_d     = parity_q;
`endif

        last_bit  = (state_q == SHIFT) && (cnt_q == CNT_W'(FRAME));
        din_ready = !rst && ((state_q == IDLE) || last_bit);
        accept    = bus.din_valid && din_ready;

        case (state_q)
            IDLE: ;
            SHIFT: begin
                if (last_bit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    data_valid_d = 1'b1;
                    done_d       = (cnt_d == CNT_W'(FRAME));
`ifdef SER_PARITY_EN
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        data_d = parity_q;
                    end else begin
                        data_d  = shift_q[WIDTH-1];
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    end
`else
                    data_d  = shift_q[WIDTH-1];
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Accepting overrides both the idle path and the end-of-frame return to IDLE,
        // which is what gives gapless back-to-back frames.
        if (accept) begin
            state_d      = SHIFT;
            data_d       = bus.din[WIDTH-1];
            shift_d      = {bus.din[WIDTH-2:0], 1'b0};
            cnt_d        = CNT_W'(1);
            data_valid_d = 1'b1;
            done_d       = 1'b0;
`ifdef SER_PARITY_EN
            parity_d     = ^bus.din;
`endif
        end

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            data_q       <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
